// File: rtl/exc_arbiter_pkg.sv
// rtl/exc_arbiter_pkg.sv - cause codes, exc-flag bit indices and FSM encodings for exc_arbiter
package exc_arbiter_pkg;

   localparam logic [4:0] EC_INT     = 5'd0;
   localparam logic [4:0] EC_TLB_MOD = 5'd1;
   localparam logic [4:0] EC_TLBL    = 5'd2;
   localparam logic [4:0] EC_TLBS    = 5'd3;
   localparam logic [4:0] EC_ADEL    = 5'd4;
   localparam logic [4:0] EC_ADES    = 5'd5;
   localparam logic [4:0] EC_SYS     = 5'd8;
   localparam logic [4:0] EC_BP      = 5'd9;
   localparam logic [4:0] EC_RI      = 5'd10;
   localparam logic [4:0] EC_OV      = 5'd12;
   // Pseudo-codes outside the architected set; CP0 decodes them specially.
   localparam logic [4:0] EC_ERET    = 5'd30;
   localparam logic [4:0] EC_NONE    = 5'd31;

   localparam int EXC_W       = 11;
   localparam int FL_IF_ADEL  = 10;
   localparam int FL_IF_TLBL  = 9;
   localparam int FL_ID_RI    = 8;
   localparam int FL_ID_SYS   = 7;
   localparam int FL_ID_BP    = 6;
   localparam int FL_ID_ERET  = 5;
   localparam int FL_EX_OV    = 4;
   localparam int FL_MEM_ADEL = 3;
   localparam int FL_MEM_ADES = 2;
   localparam int FL_MEM_TLBL = 1;
   localparam int FL_MEM_TLBS = 0;

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_RAISE      = 2'd1;
   localparam logic [1:0] S_WAIT_REDIR = 2'd2;

   typedef enum logic [1:0] {
      BV_ZERO = 2'd0,
      BV_PC   = 2'd1,
      BV_ADDR = 2'd2
   } bv_sel_e;

   typedef struct packed {
      logic [4:0] code;
      bv_sel_e    bv_sel;
   } prio_t;

endpackage

// File: rtl/exc_arbiter_prio_enc.sv
// rtl/exc_arbiter_prio_enc.sv - combinational MIPS exception priority encoder
module exc_prio_enc
   import exc_arbiter_pkg::*;
(
   input  logic             has_int_i,
   input  logic [EXC_W-1:0] flags_i,
   input  logic             tlb_mod_i,
   output logic             hit_o,
   output prio_t            sel_o
);

   always_comb begin
      hit_o        = 1'b1;
      sel_o.code   = EC_NONE;
      sel_o.bv_sel = BV_ZERO;
      if (has_int_i) begin
         sel_o.code = EC_INT;
      end else if (flags_i[FL_IF_ADEL]) begin
         sel_o.code   = EC_ADEL;
         sel_o.bv_sel = BV_PC;
      end else if (flags_i[FL_IF_TLBL]) begin
         sel_o.code   = EC_TLBL;
         sel_o.bv_sel = BV_PC;
      end else if (flags_i[FL_ID_RI]) begin
         sel_o.code = EC_RI;
      end else if (flags_i[FL_ID_SYS]) begin
         sel_o.code = EC_SYS;
      end else if (flags_i[FL_ID_BP]) begin
         sel_o.code = EC_BP;
      end else if (flags_i[FL_EX_OV]) begin
         sel_o.code = EC_OV;
      end else if (flags_i[FL_MEM_ADEL]) begin
         sel_o.code   = EC_ADEL;
         sel_o.bv_sel = BV_ADDR;
      end else if (flags_i[FL_MEM_ADES]) begin
         sel_o.code   = EC_ADES;
         sel_o.bv_sel = BV_ADDR;
      end else if (flags_i[FL_MEM_TLBL]) begin
         sel_o.code   = EC_TLBL;
         sel_o.bv_sel = BV_ADDR;
      end else if (flags_i[FL_MEM_TLBS]) begin
         sel_o.code   = EC_TLBS;
         sel_o.bv_sel = BV_ADDR;
      end else if (tlb_mod_i) begin
         sel_o.code   = EC_TLB_MOD;
         sel_o.bv_sel = BV_ADDR;
      end else if (flags_i[FL_ID_ERET]) begin
         // ERET ranks last: any real fault on the same instruction must win.
         sel_o.code = EC_ERET;
      end else begin
         hit_o = 1'b0;
      end
   end

endmodule

// File: rtl/exc_arbiter.sv
// rtl/exc_arbiter.sv - MEM/WB exception arbiter presenting one request per fault to CP0
module exc_arbiter
   import exc_arbiter_pkg::*;
#(
   parameter int REDIRECT_TIMEOUT = 4,
   parameter int PC_W             = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_valid_i,
   input  logic [PC_W-1:0]  mem_pc_i,
   input  logic             mem_in_delay_slot_i,
   input  logic [EXC_W-1:0] mem_exc_flags_i,
   input  logic             mem_tlb_mod_i,
   input  logic [PC_W-1:0]  mem_addr_i,
   input  logic             has_int_i,
   input  logic             exc_jump_flag_i,
   output logic [4:0]       exc_code_o,
   output logic [PC_W-1:0]  exc_epc_o,
   output logic [PC_W-1:0]  exc_badvaddr_o,
   output logic             commit_kill_o,
   output logic             busy_o,
   output logic             redirect_err_o
);

   localparam int CNT_W = $clog2(REDIRECT_TIMEOUT + 1);

   logic [1:0]      state_q, state_d;
   logic [4:0]      code_q, code_d;
   logic [PC_W-1:0] epc_q, epc_d;
   logic [PC_W-1:0] bva_q, bva_d;
   logic            err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic  hit;
   prio_t sel;
   logic  req;

   exc_prio_enc u_prio (
      .has_int_i (has_int_i),
      .flags_i   (mem_exc_flags_i),
      .tlb_mod_i (mem_tlb_mod_i),
      .hit_o     (hit),
      .sel_o     (sel)
   );

   assign req = mem_valid_i && (state_q == S_IDLE) && hit;

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      epc_d   = epc_q;
      bva_d   = bva_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               code_d  = sel.code;
               epc_d   = mem_in_delay_slot_i ? (mem_pc_i - PC_W'(4)) : mem_pc_i;
               case (sel.bv_sel)
                  BV_PC:   bva_d = mem_pc_i;
                  BV_ADDR: bva_d = mem_addr_i;
                  default: bva_d = '0;
               endcase
               state_d = S_RAISE;
            end
         end
         S_RAISE: begin
            code_d  = EC_NONE;
            cnt_d   = '0;
            state_d = S_WAIT_REDIR;
         end
         S_WAIT_REDIR: begin
            if (exc_jump_flag_i) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (cnt_q == CNT_W'(REDIRECT_TIMEOUT - 1)) begin
               // Give up so the pipeline is not wedged; the sticky flag records it.
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            code_d  = EC_NONE;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         code_q  <= EC_NONE;
         epc_q   <= '0;
         bva_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         epc_q   <= epc_d;
         bva_q   <= bva_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign exc_code_o     = code_q;
   assign exc_epc_o      = epc_q;
   assign exc_badvaddr_o = bva_q;
   assign commit_kill_o  = req;
   assign busy_o         = (state_q != S_IDLE);
   assign redirect_err_o = err_q;

endmodule

// File: tb/tb_exc_arbiter.sv
// tb/tb_exc_arbiter.sv - directed self-checking bench for exc_arbiter
module tb_exc_arbiter;

   localparam logic [4:0] C_NONE = 5'd31;
   localparam logic [4:0] C_ERET = 5'd30;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_valid_i = 1'b0;
   logic [31:0] mem_pc_i = '0;
   logic        mem_in_delay_slot_i = 1'b0;
   logic [10:0] mem_exc_flags_i = '0;
   logic        mem_tlb_mod_i = 1'b0;
   logic [31:0] mem_addr_i = '0;
   logic        has_int_i = 1'b0;
   logic        exc_jump_flag_i = 1'b0;
   logic [4:0]  exc_code_o;
   logic [31:0] exc_epc_o;
   logic [31:0] exc_badvaddr_o;
   logic        commit_kill_o;
   logic        busy_o;
   logic        redirect_err_o;

   int n_checks = 0;
   int n_errors = 0;

   exc_arbiter #(.REDIRECT_TIMEOUT(4), .PC_W(32)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .mem_valid_i         (mem_valid_i),
      .mem_pc_i            (mem_pc_i),
      .mem_in_delay_slot_i (mem_in_delay_slot_i),
      .mem_exc_flags_i     (mem_exc_flags_i),
      .mem_tlb_mod_i       (mem_tlb_mod_i),
      .mem_addr_i          (mem_addr_i),
      .has_int_i           (has_int_i),
      .exc_jump_flag_i     (exc_jump_flag_i),
      .exc_code_o          (exc_code_o),
      .exc_epc_o           (exc_epc_o),
      .exc_badvaddr_o      (exc_badvaddr_o),
      .commit_kill_o       (commit_kill_o),
      .busy_o              (busy_o),
      .redirect_err_o      (redirect_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      mem_valid_i         = 1'b0;
      mem_pc_i            = '0;
      mem_in_delay_slot_i = 1'b0;
      mem_exc_flags_i     = '0;
      mem_tlb_mod_i       = 1'b0;
      mem_addr_i          = '0;
      has_int_i           = 1'b0;
      exc_jump_flag_i     = 1'b0;
   endtask

   task automatic set_req(input logic [31:0] pc, input logic ds, input logic [10:0] fl,
                          input logic mod, input logic [31:0] addr, input logic hint);
      mem_valid_i         = 1'b1;
      mem_pc_i            = pc;
      mem_in_delay_slot_i = ds;
      mem_exc_flags_i     = fl;
      mem_tlb_mod_i       = mod;
      mem_addr_i          = addr;
      has_int_i           = hint;
   endtask

   // Inputs already applied in IDLE; walks RAISE and a 1-cycle WAIT_REDIR.
   task automatic raise_and_check(input string tag, input logic [4:0] code,
                                  input logic [31:0] epc, input logic [31:0] bva);
      #1;
      check({tag, ".kill"}, 32'(commit_kill_o), 32'd1);
      tick();
      clear_in();
      check({tag, ".code"}, 32'(exc_code_o), 32'(code));
      check({tag, ".epc"}, exc_epc_o, epc);
      check({tag, ".bva"}, exc_badvaddr_o, bva);
      tick();
      check({tag, ".wait_code"}, 32'(exc_code_o), 32'(C_NONE));
      exc_jump_flag_i = 1'b1;
      tick();
      exc_jump_flag_i = 1'b0;
      check({tag, ".idle"}, 32'(busy_o), 32'd0);
   endtask

   initial begin
      clear_in();
      repeat (2) tick();
      check("rst.code", 32'(exc_code_o), 32'(C_NONE));
      check("rst.epc", exc_epc_o, 32'h0);
      check("rst.bva", exc_badvaddr_o, 32'h0);
      check("rst.busy", 32'(busy_o), 32'd0);
      check("rst.err", 32'(redirect_err_o), 32'd0);
      rst = 1'b1;
      tick();

      // Syscall with busy-window checks and a second id_sys masked while busy.
      set_req(32'h8000_1000, 1'b0, 11'h080, 1'b0, 32'h0, 1'b0);
      #1;
      check("sys.kill", 32'(commit_kill_o), 32'd1);
      check("sys.busy0", 32'(busy_o), 32'd0);
      tick();
      check("sys.code", 32'(exc_code_o), 32'd8);
      check("sys.epc", exc_epc_o, 32'h8000_1000);
      check("sys.bva", exc_badvaddr_o, 32'h0);
      check("sys.busy1", 32'(busy_o), 32'd1);
      set_req(32'h8000_1004, 1'b0, 11'h080, 1'b0, 32'h0, 1'b0);
      #1;
      check("sys.mask_raise", 32'(commit_kill_o), 32'd0);
      tick();
      check("sys.busy2", 32'(busy_o), 32'd1);
      check("sys.code_none", 32'(exc_code_o), 32'(C_NONE));
      check("sys.mask_wait", 32'(commit_kill_o), 32'd0);
      exc_jump_flag_i = 1'b1;
      tick();
      clear_in();
      check("sys.idle", 32'(busy_o), 32'd0);
      check("sys.noerr", 32'(redirect_err_o), 32'd0);
      tick();
      check("sys.no_second", 32'(busy_o), 32'd0);

      // Flags without mem_valid_i produce no request.
      mem_exc_flags_i = 11'h080;
      has_int_i = 1'b1;
      #1;
      check("novalid.kill", 32'(commit_kill_o), 32'd0);
      tick();
      check("novalid.busy", 32'(busy_o), 32'd0);
      clear_in();

      set_req(32'h8000_2004, 1'b1, 11'h002, 1'b0, 32'h0040_3000, 1'b0);
      raise_and_check("dstlbl", 5'd2, 32'h8000_2000, 32'h0040_3000);
      set_req(32'h8000_3000, 1'b0, 11'h110, 1'b0, 32'h0, 1'b1);
      raise_and_check("int_wins", 5'd0, 32'h8000_3000, 32'h0);
      set_req(32'h8000_3000, 1'b0, 11'h110, 1'b0, 32'h0, 1'b0);
      raise_and_check("ri_over_ov", 5'd10, 32'h8000_3000, 32'h0);
      set_req(32'h8000_4001, 1'b0, 11'h404, 1'b0, 32'h0000_1234, 1'b0);
      raise_and_check("ifadel", 5'd4, 32'h8000_4001, 32'h8000_4001);
      set_req(32'h8000_5000, 1'b0, 11'h004, 1'b0, 32'h0000_1235, 1'b0);
      raise_and_check("ades", 5'd5, 32'h8000_5000, 32'h0000_1235);
      set_req(32'h8000_6000, 1'b0, 11'h021, 1'b0, 32'h0000_2000, 1'b0);
      raise_and_check("tlbs_over_eret", 5'd3, 32'h8000_6000, 32'h0000_2000);
      set_req(32'h8000_7000, 1'b0, 11'h000, 1'b1, 32'h0000_3000, 1'b0);
      raise_and_check("mod", 5'd1, 32'h8000_7000, 32'h0000_3000);
      set_req(32'h8000_8000, 1'b0, 11'h020, 1'b0, 32'h0000_4000, 1'b0);
      raise_and_check("eret", C_ERET, 32'h8000_8000, 32'h0);
      set_req(32'h0000_0000, 1'b1, 11'h040, 1'b0, 32'h0, 1'b0);
      raise_and_check("bp_wrap", 5'd9, 32'hFFFF_FFFC, 32'h0);

      // Interrupt held during busy is taken on the first valid cycle back in IDLE.
      set_req(32'h8000_9000, 1'b0, 11'h080, 1'b0, 32'h0, 1'b0);
      tick();
      set_req(32'h8000_9004, 1'b0, 11'h000, 1'b0, 32'h0, 1'b1);
      #1;
      check("int_hold.raise", 32'(commit_kill_o), 32'd0);
      tick();
      #1;
      check("int_hold.wait", 32'(commit_kill_o), 32'd0);
      exc_jump_flag_i = 1'b1;
      tick();
      exc_jump_flag_i = 1'b0;
      mem_pc_i = 32'h8000_9008;
      raise_and_check("int_hold", 5'd0, 32'h8000_9008, 32'h0);

      // Redirect timeout; jump during RAISE must be ignored.
      set_req(32'h8000_A000, 1'b0, 11'h080, 1'b0, 32'h0, 1'b0);
      tick();
      clear_in();
      exc_jump_flag_i = 1'b1;
      tick();
      exc_jump_flag_i = 1'b0;
      check("to.raise_jump_ignored", 32'(busy_o), 32'd1);
      repeat (3) tick();
      check("to.busy_before", 32'(busy_o), 32'd1);
      check("to.err_before", 32'(redirect_err_o), 32'd0);
      tick();
      check("to.idle", 32'(busy_o), 32'd0);
      check("to.err", 32'(redirect_err_o), 32'd1);
      set_req(32'h8000_B000, 1'b0, 11'h100, 1'b0, 32'h0, 1'b0);
      raise_and_check("after_to", 5'd10, 32'h8000_B000, 32'h0);
      check("to.sticky", 32'(redirect_err_o), 32'd1);

      // Asynchronous reset in RAISE.
      set_req(32'h8000_C000, 1'b0, 11'h080, 1'b0, 32'h0, 1'b0);
      tick();
      clear_in();
      check("ar.code_pre", 32'(exc_code_o), 32'd8);
      #1 rst = 1'b0;
      #1;
      check("ar.code", 32'(exc_code_o), 32'(C_NONE));
      check("ar.epc", exc_epc_o, 32'h0);
      check("ar.busy", 32'(busy_o), 32'd0);
      check("ar.err", 32'(redirect_err_o), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      check("ar.after", 32'(busy_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
